// File: rtl/firmware_loader.sv
// firmware_loader: receives a counted word stream from a host, writes it to program memory, reads it back
// and compares XOR checksums before releasing the program counter onto the PA bus.
module firmware_loader (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  PA,
  output logic        PA_OE,
  output logic [14:0] IO_OUT,
  output logic        IO_OE,
  input  logic [14:0] IO_IN,
  output logic        nWE,
  output logic        nOE,
  output logic        nPC_OPEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
  typedef enum logic [3:0] {
    IDLE, CNT, RX_HI, RX_LO, WRITE, RD_ADDR, RD_SAMPLE, CHECK, RUN, ERROR
  } state_e;
  state_e      state_q;
  logic [8:0]  n_q, cnt_q;
  logic [7:0]  addr_q;
  logic [14:0] word_q, wck_q, rck_q;
  logic        acc, last;
  assign acc  = RX_VALID & RX_READY;
  // a count byte of 0x00 is stored as 256, so the 9-bit compare covers the full range
  assign last = (cnt_q + 9'd1) == n_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      wck_q   <= '0;
      rck_q   <= '0;
    end else begin
      case (state_q)
        IDLE, RUN, ERROR: if (acc && RX_DATA == 8'hA5) state_q <= CNT;
        CNT: if (acc) begin
          n_q     <= {RX_DATA == 8'h00, RX_DATA};
          cnt_q   <= '0;
          addr_q  <= '0;
          wck_q   <= '0;
          state_q <= RX_HI;
        end
        RX_HI: if (acc) begin
          word_q[14:8] <= RX_DATA[6:0];
          state_q      <= RX_LO;
        end
        RX_LO: if (acc) begin
          word_q[7:0] <= RX_DATA;
          state_q     <= WRITE;
        end
        WRITE: begin
          wck_q   <= wck_q ^ word_q;
          addr_q  <= last ? 8'h00 : addr_q + 8'd1;
          cnt_q   <= last ? 9'd0 : cnt_q + 9'd1;
          rck_q   <= last ? 15'd0 : rck_q;
          state_q <= last ? RD_ADDR : RX_HI;
        end
        RD_ADDR: state_q <= RD_SAMPLE;
        RD_SAMPLE: begin
          rck_q   <= rck_q ^ IO_IN;
          addr_q  <= addr_q + 8'd1;
          cnt_q   <= cnt_q + 9'd1;
          state_q <= last ? CHECK : RD_ADDR;
        end
        CHECK: state_q <= (wck_q == rck_q) ? RUN : ERROR;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign RX_READY = !(state_q inside {WRITE, RD_ADDR, RD_SAMPLE, CHECK});
  assign PA       = addr_q;
  assign PA_OE    = state_q inside {WRITE, RD_ADDR, RD_SAMPLE};
  assign IO_OE    = state_q == WRITE;
  assign IO_OUT   = (state_q == WRITE) ? word_q : 15'd0;
  assign nWE      = state_q != WRITE;
  assign nOE      = !(state_q inside {RD_ADDR, RD_SAMPLE, RUN});
  assign nPC_OPEN = state_q != RUN;
  assign BUSY     = !(state_q inside {IDLE, RUN, ERROR});
  assign DONE     = state_q == RUN;
  assign ERR      = state_q == ERROR;
endmodule
